serial_subtractor_16: RTL and testbench
=======================================

Name: serial_subtractor_16

Overview:
Multi-cycle digit-serial unsigned subtractor with borrow-in and borrow-out. It is the inverse-operation companion to the team's 16-bit carry-select adder (in1/in2/cin to sum/cout). It computes diff = in1 - in2 - bin, DIGIT bits per clock, LSB digit first. It uses a start/busy/done handshake and sits beside the adder in the arithmetic datapath, where area matters more than latency.

Parameters:
WIDTH, 16, operand and result width in bits; must be an integer multiple of DIGIT.
DIGIT, 4, bits processed per RUN cycle; NDIG = WIDTH/DIGIT cycles per operation.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; accepted only when busy==0.
in1  input  WIDTH  minuend; sampled only on accepted start.
in2  input  WIDTH  subtrahend; sampled only on accepted start.
bin  input  1  borrow-in; sampled only on accepted start.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse; diff and bout are valid and new.
diff  output  WIDTH  (in1 - in2 - bin) mod 2^WIDTH.
bout  output  1  1 iff in1 < in2 + bin (unsigned).

Behaviour:
- Reset (rst high at a rising edge):
  - state=IDLE, digit counter=0.
  - busy=0, done=0, diff=0, bout=0.
  - Internal operand and borrow registers are cleared.
  - Reset overrides start in the same cycle.
- States:
  - IDLE: busy=0. On start=1 at edge E0, latch in1, in2 and bin into shift/borrow registers, clear the counter, go to RUN.
  - RUN: busy=1. At each edge E1..E_NDIG, process digit k=counter, LSB first: {borrow', d} = a[k] - b[k] - borrow. Write d into result digit k, update borrow, increment the counter.
  - At edge E_NDIG (last digit): write the full result into diff, write the final borrow into bout, set done=1, go to IDLE.
- Latency: done is high in the cycle after edge E_NDIG, i.e. NDIG edges after the accepting edge (4 for the defaults). busy is high for exactly NDIG cycles.
- done is a registered pulse: high for exactly one cycle, cleared at the next edge.
- diff and bout hold their last completed values through IDLE and the whole next RUN. They change only at the completion edge and never show partial results.
- start while busy=1 is ignored: no effect on state, operands or outputs.
- Back-to-back: start is accepted in the same cycle done=1 (state is IDLE). The next done then follows exactly NDIG edges later.
- Reset mid-RUN aborts the operation. No done pulse is produced, and diff/bout go to 0.
- Borrow arithmetic per digit is DIGIT+1 bits wide. The borrow is the MSB of (a_digit - b_digit - borrow) in two's complement; no signed interpretation exists anywhere.
- in1, in2 and bin may change freely after the accepting edge without affecting the result.

Test Plan:
- Reset, then start with in1=0x0000, in2=0x0000, bin=0 -> done exactly 4 cycles later; diff=0x0000, bout=0; busy high for exactly 4 cycles.
- in1=0x0003, in2=0x0001, bin=1 -> diff=0x0001, bout=0. Then in1=0x0000, in2=0x0001, bin=0 -> diff=0xFFFF, bout=1 (full borrow ripple across all digits).
- in1=0xFFFF, in2=0xFFFF, bin=1 -> diff=0xFFFF, bout=1. in1=0x1E32, in2=0x43AF, bin=0 -> diff=0xDA83, bout=1. in1=0x1E33, in2=0x1E32, bin=1 -> diff=0x0000, bout=0.
- Start in1=0x5555, in2=0x1111, bin=0. Two cycles later pulse start with in1=0xFFFF, in2=0, and change the inputs every cycle -> single done after 4 cycles with diff=0x4444, bout=0. The second start is ignored, and diff keeps its prior value until the completion edge.
- Back-to-back: assert start again during the done cycle with in1=0x0010, in2=0x0020, bin=0 -> second done exactly 4 cycles later with diff=0xFFF0, bout=1, and no idle gap required.
- Assert rst for one cycle two cycles into RUN -> no done pulse; busy=0, diff=0, bout=0 the next cycle. A fresh start afterwards completes normally.

Source files
------------

// File: rtl/serial_subtractor_16.sv
// rtl/serial_subtractor_16.sv - digit-serial unsigned subtractor with borrow-in/borrow-out
module serial_subtractor_16 #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              brw_q, brw_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              bout_q, bout_d;
  logic              done_q, done_d;

  // Current digit difference; the extra MSB is the borrow out of this digit.
  logic [DIGIT:0]    dsub;
  // Partial result with the new digit shifted in from the top, so after
  // NDIG digits the LSB digit has arrived at bit 0.
  logic [WIDTH-1:0]  res_shift;

  // Per-digit subtract and result shift, independent of state.
  always_comb begin
    dsub = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - (DIGIT+1)'(brw_q);
    res_shift = res_q >> DIGIT;
    res_shift[WIDTH-1 -: DIGIT] = dsub[DIGIT-1:0];
  end

  // Next-state logic: operand capture in IDLE, one digit per cycle in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    res_d   = res_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = in1;
          b_d     = in2;
          brw_d   = bin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        brw_d = dsub[DIGIT];
        res_d = res_shift;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Outputs update only here, so partial results are never visible.
          diff_d  = res_shift;
          bout_d  = dsub[DIGIT];
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      res_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor_16.sv
// tb/tb_serial_subtractor_16.sv - directed self-checking bench for serial_subtractor_16
module tb_serial_subtractor_16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        bin;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        bout;

  int n_vec = 0;
  int n_mis = 0;

  serial_subtractor_16 #(.WIDTH(16), .DIGIT(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // One comparison point.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from the current cycle and wait (bounded) for done.
  // Returns positioned in the done cycle.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic bi, input logic [15:0] ed, input logic eb);
    int lat;
    int bcnt;
    start = 1'b1; in1 = a; in2 = b; bin = bi;
    step();
    start = 1'b0;
    in1 = ~a; in2 = ~b; bin = ~bi;
    lat = 0;
    bcnt = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_busy_cycles"}, bcnt, 4);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_bout"}, bout, eb);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0; bin = 1'b0;
    step();
    start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_diff", diff, 0);
    chk("reset_bout", bout, 0);
    step();
    chk("idle_after_reset_busy", busy, 0);

    do_op("zero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    step();
    chk("zero_done_pulse", done, 0);
    chk("zero_busy_after", busy, 0);

    do_op("small_bin", 16'h0003, 16'h0001, 1'b1, 16'h0001, 1'b0);
    step();
    do_op("ripple", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
    step();
    do_op("all_ones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    step();
    do_op("mixed", 16'h1E32, 16'h43AF, 1'b0, 16'hDA83, 1'b1);
    step();

    // Start ignored while busy; outputs hold until completion.
    start = 1'b1; in1 = 16'h5555; in2 = 16'h1111; bin = 1'b0;
    step();
    start = 1'b0;
    chk("ign_busy_e0", busy, 1);
    chk("ign_hold_e0", diff, 16'hDA83);
    step();
    start = 1'b1; in1 = 16'hFFFF; in2 = 16'h0000; bin = 1'b1;
    step();
    chk("ign_hold_e2", diff, 16'hDA83);
    chk("ign_hold_bout_e2", bout, 1);
    start = 1'b0; in1 = 16'h1234; in2 = 16'hABCD; bin = 1'b0;
    step();
    chk("ign_no_done_e3", done, 0);
    chk("ign_hold_e3", diff, 16'hDA83);
    in1 = 16'h0F0F; in2 = 16'hF0F0; bin = 1'b1;
    step();
    chk("ign_done_e4", done, 1);
    chk("ign_diff", diff, 16'h4444);
    chk("ign_bout", bout, 0);

    // Back-to-back: start during the done cycle.
    do_op("b2b", 16'h0010, 16'h0020, 1'b0, 16'hFFF0, 1'b1);
    step();
    chk("b2b_done_pulse", done, 0);
    chk("b2b_busy_after", busy, 0);
    chk("b2b_no_restart", busy, 0);

    // Reset two cycles into RUN aborts the operation.
    start = 1'b1; in1 = 16'h1E33; in2 = 16'h1E32; bin = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_bout", bout, 0);
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        if (done) seen++;
        step();
      end
      chk("abort_no_done", seen, 0);
    end

    do_op("exact", 16'h1E33, 16'h1E32, 1'b1, 16'h0000, 1'b0);
    step();
    do_op("after_abort", 16'h5555, 16'h1111, 1'b0, 16'h4444, 1'b0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
